approx_sqrt_iter: RTL

APPROX_SQRT_ITER -- requirements
Module: approx_sqrt_iter

---
 rtl/approx_sqrt_pkg.sv | 14 +
 rtl/sqrt_iter_step.sv | 35 +++
 rtl/approx_sqrt_iter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/approx_sqrt_pkg.sv
// Shared FSM state type and parameter-range limits for the iterative square-root block.
package approx_sqrt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned W_MIN = 4;
  localparam int unsigned W_MAX = 32;
  localparam int unsigned K_MIN = 1;

endpackage

// File: rtl/sqrt_iter_step.sv
// One restoring square-root iteration: bring down the next radicand pair and try
// to extend the root by a 1 bit.
module sqrt_iter_step
  import approx_sqrt_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic [W/2+1:0] rem,
  input  logic [W/2-1:0] root,
  input  logic [1:0]     pair,
  output logic [W/2+1:0] next_rem,
  output logic [W/2-1:0] next_root
);

  localparam int unsigned HW = W / 2;
  localparam int unsigned RW = HW + 2;
  localparam int unsigned EW = RW + 2;

  logic [EW-1:0] shifted;
  logic [EW-1:0] trial;

  // Internal width is two bits wider than the remainder so the shift is lossless;
  // the remainder invariant rem <= 2*root keeps the narrowed result exact.
  always_comb begin
    shifted   = {rem, pair};
    trial     = EW'({root, 2'b01});
    next_rem  = RW'(shifted);
    next_root = HW'({root, 1'b0});
    if (shifted >= trial) begin
      next_rem  = RW'(shifted - trial);
      next_root = HW'({root, 1'b1});
    end
  end

endmodule

// File: rtl/approx_sqrt_iter.sv
// Iterative integer square root with a selectable approximate mode that computes only
// the top K root bits and fills the remaining L bits with a midpoint estimate.
module approx_sqrt_iter
  import approx_sqrt_pkg::*;
#(
  parameter int unsigned W = 16,
  parameter int unsigned K = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_data,
  input  logic           in_exact,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W/2-1:0] out_data,
  output logic           out_exact,
  output logic           busy
);

  localparam int unsigned HW = W / 2;
  localparam int unsigned RW = HW + 2;
  localparam int unsigned L  = HW - K;
  localparam int unsigned CW = $clog2(HW + 1);

  generate
    if ((W % 2) != 0 || W < W_MIN || W > W_MAX) begin : g_bad_w
      $error("approx_sqrt_iter: W must be even and within 4..32");
    end
    if (K < K_MIN || K > HW) begin : g_bad_k
      $error("approx_sqrt_iter: K must satisfy 1 <= K <= W/2");
    end
  endgenerate

  state_t        state;
  logic [W-1:0]  data;
  logic [RW-1:0] rem;
  logic [HW-1:0] root;
  logic [CW-1:0] cnt;
  logic [CW-1:0] last;
  logic          exact;

  logic [RW-1:0] next_rem;
  logic [HW-1:0] next_root;
  logic [HW-1:0] approx_c;

  sqrt_iter_step #(.W(W)) u_step (
    .rem       (rem),
    .root      (root),
    .pair      (data[W-1:W-2]),
    .next_rem  (next_rem),
    .next_root (next_root)
  );

  // Midpoint fill: any leftover remainder or unprocessed radicand bit means the true
  // root lies strictly inside the L-bit window, so report its centre.
  generate
    if (L > 0) begin : g_fill
      logic [HW-1:0] fill_c;
      assign fill_c   = (next_rem != '0 || data[W-3:0] != '0) ? (HW'(1) << (L - 1)) : '0;
      assign approx_c = (next_root << L) | fill_c;
    end else begin : g_no_fill
      assign approx_c = next_root;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      out_data  <= '0;
      out_exact <= 1'b0;
      data      <= '0;
      rem       <= '0;
      root      <= '0;
      cnt       <= '0;
      last      <= '0;
      exact     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            data     <= in_data;
            exact    <= in_exact;
            rem      <= '0;
            root     <= '0;
            cnt      <= '0;
            last     <= in_exact ? CW'(HW - 1) : CW'(K - 1);
            state    <= CALC;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        CALC: begin
          rem  <= next_rem;
          root <= next_root;
          data <= {data[W-3:0], 2'b00};
          cnt  <= cnt + CW'(1);
          if (cnt == last) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out_data  <= exact ? next_root : approx_c;
            out_exact <= exact;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
